// File: rtl/viterbi_pkg.sv
// Shared constants and FSM encoding for the Viterbi frame sequencer.
// Rate-1/2, K=3 code: two encoded bits per symbol, K-1 termination symbols.
package viterbi_pkg;

    localparam int SYM_W        = 2;
    localparam int CONSTRAINT_K = 3;
    localparam int TAIL_LEN_DEF = CONSTRAINT_K - 1;

    localparam logic [SYM_W-1:0] FLUSH_SYM = 2'b00;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_PREP,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } state_t;

endpackage

// File: rtl/viterbi_frame_ctrl_if.sv
// Symbol input stream and decoded-bit output stream of the frame sequencer.
// master = stream source / bit sink side, slave = the sequencer itself.
interface viterbi_frame_ctrl_if;
    import viterbi_pkg::*;

    logic [SYM_W-1:0] s_symbol;
    logic             s_valid;
    logic             s_last;
    logic             s_ready;
    logic             m_bit;
    logic             m_valid;
    logic             m_last;

    modport master (
        output s_symbol, s_valid, s_last,
        input  s_ready,
        input  m_bit, m_valid, m_last
    );

    modport slave (
        input  s_symbol, s_valid, s_last,
        output s_ready,
        output m_bit, m_valid, m_last
    );

endinterface

// File: rtl/viterbi_sym_buffer.sv
// Single-port frame buffer: counted writes during load, registered read during burst.
// The read register doubles as the decoder input register and reads FLUSH_SYM when idle.
module viterbi_sym_buffer
    import viterbi_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int CNT_W  = $clog2(DEPTH + 1),
    parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [SYM_W-1:0]  wr_data,
    input  logic              cnt_clr,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [CNT_W-1:0]  wcnt,
    output logic [SYM_W-1:0]  rd_data
);

    logic [SYM_W-1:0]  mem_reg [DEPTH];
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  wcnt_reg;
    logic [SYM_W-1:0]  rd_data_reg;

    // One shared address port: writes and reads never overlap in time.
    assign addr = wr_en ? wcnt_reg[ADDR_W-1:0] : rd_addr;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_reg[addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_reg <= '0;
        end else if (rd_en) begin
            rd_data_reg <= mem_reg[addr];
        end else begin
            rd_data_reg <= FLUSH_SYM;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || cnt_clr) begin
            wcnt_reg <= '0;
        end else if (wr_en) begin
            wcnt_reg <= wcnt_reg + 1'b1;
        end
    end

    assign wcnt    = wcnt_reg;
    assign rd_data = rd_data_reg;

endmodule

// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer for a free-running rate-1/2 Viterbi decoder: buffers a frame,
// bursts it through the decoder with flush symbols, and emits aligned info bits.
module viterbi_frame_ctrl
    import viterbi_pkg::*;
#(
    parameter int FRAME_LEN   = 32,
    parameter int TAIL_LEN    = TAIL_LEN_DEF,
    parameter int DEC_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    viterbi_frame_ctrl_if.slave  strm,
    output logic [SYM_W-1:0]     dec_encoded_signal,
    output logic                 dec_reset,
    input  logic                 dec_decoded_signal,
    output logic                 busy,
    output logic                 frame_err
);

    localparam int CNT_W  = $clog2(FRAME_LEN + 1);
    localparam int ADDR_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int PTR_W  = $clog2(FRAME_LEN + DEC_LATENCY + 2);

    state_t            state_reg, state_next;
    logic [PTR_W-1:0]  rptr_reg, rptr_next;
    logic              s_ready_reg, s_ready_next;
    logic              busy_reg, busy_next;
    logic              dec_reset_reg, dec_reset_next;
    logic              frame_err_reg, frame_err_next;
    logic              m_bit_reg, m_bit_next;
    logic              m_valid_reg, m_valid_next;
    logic              m_last_reg, m_last_next;

    logic              accept;
    logic              frame_end;
    logic              too_short;
    logic              cnt_clr;
    logic              rd_en;
    logic              sample;
    logic [CNT_W-1:0]  wcnt;
    logic [PTR_W-1:0]  n_ext;
    logic [PTR_W-1:0]  hi_ptr;
    logic [SYM_W-1:0]  rd_data;

    viterbi_sym_buffer #(
        .DEPTH  (FRAME_LEN),
        .CNT_W  (CNT_W),
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (accept),
        .wr_data (strm.s_symbol),
        .cnt_clr (cnt_clr),
        .rd_en   (rd_en),
        .rd_addr (rptr_reg[ADDR_W-1:0]),
        .wcnt    (wcnt),
        .rd_data (rd_data)
    );

    assign accept    = (state_reg == ST_LOAD) && strm.s_valid && s_ready_reg;
    assign frame_end = accept && (strm.s_last || (wcnt == CNT_W'(FRAME_LEN - 1)));
    assign too_short = (wcnt < CNT_W'(TAIL_LEN));
    assign n_ext     = PTR_W'(wcnt);
    // rptr runs one ahead of the RUN index, so symbol j's bit arrives when rptr == j+1+DEC_LATENCY.
    assign hi_ptr    = n_ext - PTR_W'(TAIL_LEN) + PTR_W'(DEC_LATENCY);
    assign sample    = ((state_reg == ST_RUN) || (state_reg == ST_FLUSH))
                       && (rptr_reg > PTR_W'(DEC_LATENCY)) && (rptr_reg <= hi_ptr);

    always_comb begin
        state_next     = state_reg;
        cnt_clr        = 1'b0;
        frame_err_next = 1'b0;
        case (state_reg)
            ST_LOAD: begin
                if (frame_end) begin
                    frame_err_next = too_short || !strm.s_last;
                    if (too_short) begin
                        cnt_clr = 1'b1;
                    end else begin
                        state_next = ST_PREP;
                    end
                end
            end
            ST_PREP:  state_next = ST_RUN;
            ST_RUN: begin
                if (rptr_reg == n_ext) begin
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (rptr_reg == n_ext + PTR_W'(DEC_LATENCY)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_LOAD;
                cnt_clr    = 1'b1;
            end
            default:  state_next = ST_LOAD;
        endcase

        rptr_next      = ((state_reg == ST_LOAD) || (state_reg == ST_DONE)) ? '0 : rptr_reg + 1'b1;
        // Control outputs are registered from the next state so they line up with it.
        s_ready_next   = (state_next == ST_LOAD);
        busy_next      = (state_next != ST_LOAD);
        dec_reset_next = !((state_next == ST_RUN) || (state_next == ST_FLUSH));
        rd_en          = (state_next == ST_RUN);
        m_valid_next   = sample;
        m_bit_next     = sample && dec_decoded_signal;
        m_last_next    = sample && (rptr_reg == hi_ptr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_LOAD;
            rptr_reg      <= '0;
            s_ready_reg   <= 1'b1;
            busy_reg      <= 1'b0;
            dec_reset_reg <= 1'b1;
            frame_err_reg <= 1'b0;
            m_bit_reg     <= 1'b0;
            m_valid_reg   <= 1'b0;
            m_last_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            rptr_reg      <= rptr_next;
            s_ready_reg   <= s_ready_next;
            busy_reg      <= busy_next;
            dec_reset_reg <= dec_reset_next;
            frame_err_reg <= frame_err_next;
            m_bit_reg     <= m_bit_next;
            m_valid_reg   <= m_valid_next;
            m_last_reg    <= m_last_next;
        end
    end

    assign strm.s_ready       = s_ready_reg;
    assign strm.m_bit         = m_bit_reg;
    assign strm.m_valid       = m_valid_reg;
    assign strm.m_last        = m_last_reg;
    assign dec_encoded_signal = rd_data;
    assign dec_reset          = dec_reset_reg;
    assign busy               = busy_reg;
    assign frame_err          = frame_err_reg;

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Directed bench for viterbi_frame_ctrl with a stub decoder (delayed encoded bit 0).
// A negedge monitor logs decoder stimulus and output bits; each test compares against constants.
module tb_viterbi_frame_ctrl;
    import viterbi_pkg::*;

    localparam int FRAME_LEN = 32;
    localparam int TAIL      = 2;
    localparam int LAT       = 1;
    localparam logic [15:0] F2_PK = 16'b00_10_11_00_00_01_00_01;

    typedef struct {
        int          nbits;
        logic [63:0] bits;
        int          nlast;
        int          last_pos;
        int          nerr;
        int          ndec;
        logic [79:0] dec;
        int          dec_span;
        int          m_span;
        int          prep_gap;
        int          lat_gap;
        int          sready_lo;
        int          busy_bad;
        int          stray;
    } obs_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [SYM_W-1:0] dec_enc;
    logic             dec_reset;
    logic             dec_dec_q = 1'b0;
    logic             busy;
    logic             frame_err;
    int               errors = 0;
    int               checks = 0;

    always #5 clk = ~clk;

    viterbi_frame_ctrl_if strm();

    viterbi_frame_ctrl #(
        .FRAME_LEN   (FRAME_LEN),
        .TAIL_LEN    (TAIL),
        .DEC_LATENCY (LAT)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .strm               (strm.slave),
        .dec_encoded_signal (dec_enc),
        .dec_reset          (dec_reset),
        .dec_decoded_signal (dec_dec_q),
        .busy               (busy),
        .frame_err          (frame_err)
    );

    always @(posedge clk) dec_dec_q <= dec_reset ? 1'b0 : dec_enc[0];

    int         cyc = 0;
    logic [1:0] dec_q [$];
    int         dec_cyc_q [$];
    logic       m_q [$];
    int         m_cyc_q [$];
    int         last_pos_q [$];
    int         acc_cyc_q [$];
    int         ferr_cnt = 0;
    int         sready_lo = 0;
    int         busy_bad = 0;
    int         stray_last = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset) begin
            if (!dec_reset) begin
                dec_q.push_back(dec_enc);
                dec_cyc_q.push_back(cyc);
            end
            if (strm.m_valid) begin
                m_q.push_back(strm.m_bit);
                m_cyc_q.push_back(cyc);
                if (strm.m_last) last_pos_q.push_back(m_q.size() - 1);
            end else if (strm.m_last) begin
                stray_last = stray_last + 1;
            end
            if (strm.s_valid && strm.s_ready) acc_cyc_q.push_back(cyc);
            if (frame_err) ferr_cnt = ferr_cnt + 1;
            if (!strm.s_ready) sready_lo = sready_lo + 1;
            if (busy == strm.s_ready) busy_bad = busy_bad + 1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_beat(input logic [1:0] sym, input bit last);
        bit ok;
        ok = 1'b0;
        strm.s_symbol = sym;
        strm.s_last   = last;
        strm.s_valid  = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (strm.s_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout: s_ready=%0b after 100 cycles, required 1", strm.s_ready);
        end
        @(posedge clk);
        #1;
        strm.s_valid  = 1'b0;
        strm.s_last   = 1'b0;
        strm.s_symbol = 2'b00;
    endtask

    task automatic load_frame(input logic [1:0] syms [32], input int n, input bit use_last,
                              input int max_gap);
        int gap;
        for (int i = 0; i < n; i++) begin
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            if (gap > 0) begin
                repeat (gap) @(posedge clk);
                #1;
            end
            send_beat(syms[i], use_last && (i == n - 1));
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (strm.s_ready) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL idle_timeout: s_ready=%0b after 200 cycles, required 1", strm.s_ready);
        end
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input string name, input logic [1:0] syms [32], input int n,
                             input bit use_last, input int max_gap, output obs_t o);
        int d0, m0, l0, e0, s0, b0, t0;
        d0 = dec_q.size(); m0 = m_q.size(); l0 = last_pos_q.size();
        e0 = ferr_cnt; s0 = sready_lo; b0 = busy_bad; t0 = stray_last;
        load_frame(syms, n, use_last, max_gap);
        wait_idle();
        o.nbits = m_q.size() - m0;
        o.bits  = '0;
        for (int i = 0; i < o.nbits && i < 64; i++) o.bits[i] = m_q[m0 + i];
        o.nlast    = last_pos_q.size() - l0;
        o.last_pos = (o.nlast > 0) ? last_pos_q[l0] - m0 : -1;
        o.nerr     = ferr_cnt - e0;
        o.ndec     = dec_q.size() - d0;
        o.dec      = '0;
        for (int i = 0; i < o.ndec && i < 40; i++) o.dec[2*i +: 2] = dec_q[d0 + i];
        o.dec_span = (o.ndec > 0) ? dec_cyc_q[d0 + o.ndec - 1] - dec_cyc_q[d0] + 1 : 0;
        o.m_span   = (o.nbits > 0) ? m_cyc_q[m0 + o.nbits - 1] - m_cyc_q[m0] + 1 : 0;
        o.prep_gap = (o.ndec > 0) ? dec_cyc_q[d0] - acc_cyc_q[acc_cyc_q.size() - 1] : -1;
        o.lat_gap  = (o.ndec > 0 && o.nbits > 0) ? m_cyc_q[m0] - dec_cyc_q[d0] : -1;
        o.sready_lo = sready_lo - s0;
        o.busy_bad  = busy_bad - b0;
        o.stray     = stray_last - t0;
        $display("frame %s: beats=%0d bits_out=%0d bits=%h m_last_at=%0d frame_err=%0d dec_syms=%0d",
                 name, n, o.nbits, o.bits, o.last_pos, o.nerr, o.ndec);
    endtask

    task automatic test_reset();
        logic [8:0] obs;
        strm.s_valid = 1'b0; strm.s_last = 1'b0; strm.s_symbol = 2'b00;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            obs = {strm.s_ready, busy, strm.m_valid, dec_reset, frame_err, strm.m_last,
                   strm.m_bit, dec_enc};
            checks++;
            if (obs !== 9'b100100000) begin
                errors++;
                $display("FAIL reset_state[%0d]: got %b want 100100000", i, obs);
            end
            if (i == 0) reset = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic(input string name, input int max_gap);
        logic [1:0] syms [32];
        obs_t o;
        for (int i = 0; i < 32; i++) syms[i] = (i < 8) ? F2_PK[2*i +: 2] : 2'b00;
        run_frame(name, syms, 8, 1'b1, max_gap, o);
        checks++; if (o.nbits !== 6) begin errors++; $display("FAIL %s_nbits: got %0d want 6", name, o.nbits); end
        checks++; if (o.bits !== 64'h25) begin errors++; $display("FAIL %s_bits: got %h want 25", name, o.bits); end
        checks++; if (o.m_span !== 6) begin errors++; $display("FAIL %s_m_span: got %0d want 6", name, o.m_span); end
        checks++; if (o.nlast !== 1 || o.last_pos !== 5) begin errors++; $display("FAIL %s_m_last: got count %0d at %0d want 1 at 5", name, o.nlast, o.last_pos); end
        checks++; if (o.nerr !== 0) begin errors++; $display("FAIL %s_frame_err: got %0d want 0", name, o.nerr); end
        checks++; if (o.ndec !== 9 || o.dec !== {62'd0, 2'b00, F2_PK}) begin errors++; $display("FAIL %s_dec_syms: got %0d syms %h want 9 syms %h", name, o.ndec, o.dec, {2'b00, F2_PK}); end
        checks++; if (o.dec_span !== 9) begin errors++; $display("FAIL %s_dec_span: got %0d want 9", name, o.dec_span); end
        checks++; if (o.prep_gap !== 2) begin errors++; $display("FAIL %s_prep_gap: got %0d want 2", name, o.prep_gap); end
        checks++; if (o.lat_gap !== LAT + 1) begin errors++; $display("FAIL %s_out_latency: got %0d want %0d", name, o.lat_gap, LAT + 1); end
        checks++; if (o.sready_lo !== 11) begin errors++; $display("FAIL %s_s_ready_low: got %0d want 11", name, o.sready_lo); end
        checks++; if (o.busy_bad !== 0 || o.stray !== 0) begin errors++; $display("FAIL %s_busy_last: got busy_bad %0d stray_last %0d want 0 0", name, o.busy_bad, o.stray); end
    endtask

    task automatic test_truncate();
        logic [1:0] syms [32];
        obs_t o;
        for (int i = 0; i < 32; i++) syms[i] = 2'b11;
        run_frame("truncate", syms, 32, 1'b0, 0, o);
        checks++; if (o.nerr !== 1) begin errors++; $display("FAIL trunc_frame_err: got %0d want 1", o.nerr); end
        checks++; if (o.nbits !== 30 || o.bits !== 64'h3FFF_FFFF) begin errors++; $display("FAIL trunc_bits: got %0d bits %h want 30 bits 3fffffff", o.nbits, o.bits); end
        checks++; if (o.nlast !== 1 || o.last_pos !== 29) begin errors++; $display("FAIL trunc_m_last: got count %0d at %0d want 1 at 29", o.nlast, o.last_pos); end
        checks++; if (o.m_span !== 30) begin errors++; $display("FAIL trunc_m_span: got %0d want 30", o.m_span); end
        checks++; if (o.ndec !== 33 || o.dec !== 80'h0000_FFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL trunc_dec_syms: got %0d syms %h", o.ndec, o.dec); end
        checks++; if (o.sready_lo !== 35) begin errors++; $display("FAIL trunc_s_ready_low: got %0d want 35", o.sready_lo); end
    endtask

    task automatic test_short();
        logic [1:0] syms [32];
        obs_t o;
        for (int i = 0; i < 32; i++) syms[i] = 2'b00;
        syms[0] = 2'b01;
        syms[1] = 2'b10;
        run_frame("short", syms, 2, 1'b1, 0, o);
        checks++; if (o.nerr !== 1) begin errors++; $display("FAIL short_frame_err: got %0d want 1", o.nerr); end
        checks++; if (o.nbits !== 0 || o.nlast !== 0) begin errors++; $display("FAIL short_m_valid: got %0d bits %0d last want 0 0", o.nbits, o.nlast); end
        checks++; if (o.ndec !== 0) begin errors++; $display("FAIL short_dec_reset: got %0d released cycles want 0", o.ndec); end
        checks++; if (o.sready_lo !== 0) begin errors++; $display("FAIL short_s_ready: got %0d low cycles want 0", o.sready_lo); end
    endtask

    task automatic test_reset_mid();
        logic [1:0] syms [32];
        logic [5:0] obs;
        bit ok;
        for (int i = 0; i < 32; i++) syms[i] = (i < 8) ? F2_PK[2*i +: 2] : 2'b00;
        load_frame(syms, 8, 1'b1, 0);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!dec_reset) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL mid_run_start: dec_reset=%0b after 20 cycles, required 0", dec_reset);
        end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (strm.m_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre_reset_valid: got %0b want 1", strm.m_valid);
        end
        @(negedge clk);
        obs = {strm.m_valid, dec_reset, busy, strm.s_ready, strm.m_last, frame_err};
        checks++;
        if (obs !== 6'b010100) begin
            errors++;
            $display("FAIL mid_reset_state: got %b want 010100 (m_valid,dec_reset,busy,s_ready,m_last,frame_err)", obs);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        $display("frame mid_reset: reset applied in RUN cycle 3");
        test_basic("after_reset", 0);
    endtask

    initial begin
        strm.s_valid  = 1'b0;
        strm.s_last   = 1'b0;
        strm.s_symbol = 2'b00;
        test_reset();
        test_basic("basic", 0);
        test_basic("bubbles", 3);
        test_truncate();
        test_short();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/viterbi_frame_ctrl.md
Name: viterbi_frame_ctrl

Overview:
Frame sequencer for the rate-1/2 Viterbi_Decoder (2-bit encoded_signal in, 1 decoded bit out, free-running with no enable). It accepts a frame of encoded symbols over a valid/ready stream and buffers the whole frame. It then resets the decoder, bursts the symbols into it on consecutive cycles, and appends flush symbols to cover decoder latency. It aligns the decoded bits to symbol index, strips tail bits, and emits the information bits with valid/last.

Parameters:
FRAME_LEN, 32, max symbols per frame (buffer depth)
TAIL_LEN, 2, encoder termination symbols per frame (K-1); their decoded bits are discarded
DEC_LATENCY, 1, cycles from symbol i on dec_encoded_signal to its decoded bit on dec_decoded_signal
CNT_W, clog2(FRAME_LEN+1), derived localparam, counter width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
s_symbol  in  2  encoded symbol, bit1 = G1 output, bit0 = G0 output
s_valid  in  1  s_symbol valid
s_last  in  1  final symbol of frame (includes tail)
s_ready  out  1  controller accepts symbol
dec_encoded_signal  out  2  to decoder encoded_signal
dec_reset  out  1  to decoder reset
dec_decoded_signal  in  1  from decoder decoded_signal
m_bit  out  1  decoded information bit
m_valid  out  1  m_bit valid (no back-pressure)
m_last  out  1  last information bit of frame
busy  out  1  high in any state other than LOAD
frame_err  out  1  one-cycle pulse on truncated or too-short frame

Behaviour:
- Reset (sync, any state): state=LOAD, counters=0, s_ready=1, dec_reset=1, dec_encoded_signal=0, m_valid=0, m_last=0, m_bit=0, busy=0, frame_err=0. Buffer contents are discarded.
- FSM states are LOAD, PREP, RUN, FLUSH, DONE.
- LOAD:
  - s_ready=1; a beat is accepted when s_valid&s_ready and is written to buf[wcnt]; wcnt++.
  - The frame ends on a beat with s_last=1, or on the FRAME_LEN-th beat (truncation: frame_err pulses, and the frame proceeds with N=FRAME_LEN).
  - s_ready drops the cycle after the ending beat.
  - Gaps in s_valid are legal.
- Length check: if N <= TAIL_LEN, frame_err pulses, the frame is dropped, the FSM stays in LOAD, and the decoder is never released from reset.
- PREP: one cycle; dec_reset=1; prefetch buf[0].
- RUN: N consecutive cycles; in cycle i the decoder sees dec_encoded_signal=buf[i] and dec_reset=0.
- FLUSH: DEC_LATENCY cycles of dec_encoded_signal=2'b00 with dec_reset=0.
- DONE: one cycle; dec_reset=1, wcnt=0; then LOAD.
- Alignment:
  - Let t0 be the first RUN cycle. The bit for symbol j is sampled from dec_decoded_signal in cycle t0+j+DEC_LATENCY.
  - For j < N-TAIL_LEN: registered and presented on m_bit with m_valid=1 one cycle later.
  - For j >= N-TAIL_LEN: ignored.
  - Result: N-TAIL_LEN consecutive m_valid cycles; m_last=1 together with the final one.
- dec_reset=1 in LOAD, PREP and DONE, and the cycle after any reset edge. dec_reset=0 only in RUN/FLUSH.
- All outputs are registered. Frame throughput is N + DEC_LATENCY + 2 cycles plus load time.
- A new frame is never accepted while busy; there is no overlap between frames.

Decomposition:
- viterbi_pkg: SYM_W=2, CONSTRAINT_K=3, default TAIL_LEN, state encoding (LOAD/PREP/RUN/FLUSH/DONE), flush symbol constant 2'b00.
- Sub-module viterbi_sym_buffer: FRAME_LEN x 2-bit single-port storage with write counter and 1-cycle registered read. The FSM, alignment counter and output stage stay in viterbi_frame_ctrl.

Test Plan:
Bench uses a stub decoder: dec_decoded_signal = dec_encoded_signal[0] delayed DEC_LATENCY cycles, zeroed while dec_reset. Defaults otherwise.
1. Reset for 2 cycles -> s_ready=1, busy=0, m_valid=0, dec_reset=1, frame_err=0; these values hold until the first beat.
2. Frame 1,0,1,0,0,3,2,0 (s_last on 8th beat) -> decoder sees those 8 symbols on consecutive cycles after one PREP cycle with dec_reset=1; then one 2'b00 flush. m_bit=1,0,1,0,0,1 on 6 consecutive cycles, m_last on the 6th; s_ready low from the cycle after beat 8 until return to LOAD.
3. Same frame with random s_valid bubbles during LOAD -> identical decoder stimulus and m_bit sequence to scenario 2.
4. 32 beats of symbol 3 without s_last -> frame_err one pulse, 30 bits of 1 out, m_last on the 30th.
5. Frame of 2 symbols (s_last on 2nd) -> frame_err pulse, no m_valid, dec_reset never 0, s_ready stays 1.
6. Reset asserted at RUN cycle 3 of scenario 2 -> next cycle m_valid=0, dec_reset=1, busy=0, s_ready=1, no m_last. A following scenario-2 frame produces the correct 6 bits.
